// File: rtl/abs_diff_accum.sv
// Block SAD accumulator: sums N unsigned 9-bit differences with saturation,
// tracks the block maximum and holds each result on a valid/ready output.
module abs_diff_accum #(
    parameter int N     = 8,
    parameter int SUM_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [8:0]       diff,
    input  logic             flush,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [SUM_W-1:0] sum,
    output logic [8:0]       max_diff,
    output logic             sat
);
    localparam int CNT_W = $clog2(N);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(N - 1);

    // Handshake: a sample moves on an edge where in_valid && in_ready; a
    // result moves on an edge where out_valid && out_ready. in_ready is a
    // pure decode of the state register, never of out_ready.
    typedef enum logic {
        ACC  = 1'b0,
        HOLD = 1'b1
    } state_t;

    state_t state_q, state_d;

    logic [SUM_W-1:0] acc_q, acc_d;
    logic [8:0]       mx_q, mx_d;
    logic             ovf_q, ovf_d;
    logic [CNT_W-1:0] cnt_q;
    logic [SUM_W:0]   add_ext;
    logic             accept;
    logic             last;

    assign accept = in_valid && in_ready;
    assign last   = (cnt_q == LAST);

    // FSM: state register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= ACC;
        else     state_q <= state_d;
    end

    // FSM: next state; flush discards the Nth sample too, so no HOLD entry
    always_comb begin
        state_d = state_q;
        case (state_q)
            ACC:     if (accept && last && !flush) state_d = HOLD;
            HOLD:    if (out_ready)                state_d = ACC;
            default: state_d = ACC;
        endcase
    end

    // FSM: outputs
    always_comb begin
        in_ready  = (state_q == ACC);
        out_valid = (state_q == HOLD);
    end

    // Next-sample arithmetic; once ovf is set the sum stays pinned at all ones
    always_comb begin
        add_ext = {1'b0, acc_q} + {{(SUM_W - 8){1'b0}}, diff};
        ovf_d   = ovf_q | add_ext[SUM_W];
        acc_d   = ovf_d ? '1 : add_ext[SUM_W-1:0];
        mx_d    = (diff > mx_q) ? diff : mx_q;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc_q    <= '0;
            mx_q     <= '0;
            ovf_q    <= 1'b0;
            cnt_q    <= '0;
            sum      <= '0;
            max_diff <= '0;
            sat      <= 1'b0;
        end else if (state_q == ACC) begin
            if (flush) begin
                acc_q <= '0;
                mx_q  <= '0;
                ovf_q <= 1'b0;
                cnt_q <= '0;
            end else if (accept) begin
                if (last) begin
                    sum      <= acc_d;
                    max_diff <= mx_d;
                    sat      <= ovf_d;
                    acc_q    <= '0;
                    mx_q     <= '0;
                    ovf_q    <= 1'b0;
                    cnt_q    <= '0;
                end else begin
                    acc_q <= acc_d;
                    mx_q  <= mx_d;
                    ovf_q <= ovf_d;
                    cnt_q <= cnt_q + CNT_W'(1);
                end
            end
        end
    end

endmodule

// File: tb/tb_abs_diff_accum.sv
// Directed bench for abs_diff_accum: a N=4/SUM_W=16 instance and a
// N=8/SUM_W=10 instance for the saturation case, sharing clock and reset.
module tb_abs_diff_accum;
    logic clk = 1'b0;
    logic rst = 1'b0;

    logic        in_valid_a = 1'b0, flush_a = 1'b0, out_ready_a = 1'b1;
    logic [8:0]  diff_a = '0;
    logic        in_ready_a, out_valid_a, sat_a;
    logic [15:0] sum_a;
    logic [8:0]  max_a;

    logic        in_valid_b = 1'b0, flush_b = 1'b0, out_ready_b = 1'b1;
    logic [8:0]  diff_b = '0;
    logic        in_ready_b, out_valid_b, sat_b;
    logic [9:0]  sum_b;
    logic [8:0]  max_b;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    abs_diff_accum #(.N(4), .SUM_W(16)) u_a (
        .clk(clk), .rst(rst), .in_valid(in_valid_a), .in_ready(in_ready_a),
        .diff(diff_a), .flush(flush_a), .out_valid(out_valid_a),
        .out_ready(out_ready_a), .sum(sum_a), .max_diff(max_a), .sat(sat_a)
    );

    abs_diff_accum #(.N(8), .SUM_W(10)) u_b (
        .clk(clk), .rst(rst), .in_valid(in_valid_b), .in_ready(in_ready_b),
        .diff(diff_b), .flush(flush_b), .out_valid(out_valid_b),
        .out_ready(out_ready_b), .sum(sum_b), .max_diff(max_b), .sat(sat_b)
    );

    // Drivers: every task starts and ends 1 time unit after a rising edge.
    task automatic send_a(input logic [8:0] d);
        in_valid_a = 1'b1;
        diff_a     = d;
        @(posedge clk); #1;
        in_valid_a = 1'b0;
    endtask

    task automatic send_b(input logic [8:0] d);
        in_valid_b = 1'b1;
        diff_b     = d;
        @(posedge clk); #1;
        in_valid_b = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) begin @(posedge clk); #1; end
    endtask

    task automatic test_reset;
        #1 rst = 1'b1;
        #3;
        repeat (2) @(posedge clk);
        @(negedge clk) rst = 1'b0;
        @(posedge clk); #1;
        n_checks++; if (out_valid_a !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid_a got %b want 0", out_valid_a); end
        n_checks++; if (in_ready_a !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready_a got %b want 1", in_ready_a); end
        n_checks++; if ({sum_a, max_a, sat_a} !== 26'd0) begin n_fail++; $display("FAIL reset_outputs_a got sum=%0d max=%0d sat=%b want 0", sum_a, max_a, sat_a); end
        n_checks++; if ({out_valid_b, sum_b, max_b, sat_b} !== 21'd0 || in_ready_b !== 1'b1) begin n_fail++; $display("FAIL reset_b got ov=%b rdy=%b sum=%0d want 0/1/0", out_valid_b, in_ready_b, sum_b); end
    endtask

    task automatic test_back_to_back;
        out_ready_a = 1'b1;
        in_valid_a  = 1'b1;
        diff_a = 9'd3;   @(posedge clk); #1;
        diff_a = 9'd10;  @(posedge clk); #1;
        diff_a = 9'd0;   @(posedge clk); #1;
        n_checks++; if (out_valid_a !== 1'b0) begin n_fail++; $display("FAIL b2b_early_valid got %b want 0", out_valid_a); end
        diff_a = 9'd255; @(posedge clk); #1;
        in_valid_a = 1'b0;
        n_checks++; if (out_valid_a !== 1'b1) begin n_fail++; $display("FAIL b2b_out_valid got %b want 1", out_valid_a); end
        n_checks++; if (in_ready_a !== 1'b0) begin n_fail++; $display("FAIL b2b_in_ready_hold got %b want 0", in_ready_a); end
        n_checks++; if (sum_a !== 16'd268) begin n_fail++; $display("FAIL b2b_sum got %0d want 268", sum_a); end
        n_checks++; if (max_a !== 9'd255) begin n_fail++; $display("FAIL b2b_max got %0d want 255", max_a); end
        n_checks++; if (sat_a !== 1'b0) begin n_fail++; $display("FAIL b2b_sat got %b want 0", sat_a); end
        @(posedge clk); #1;
        n_checks++; if (in_ready_a !== 1'b1 || out_valid_a !== 1'b0) begin n_fail++; $display("FAIL b2b_release got rdy=%b ov=%b want 1/0", in_ready_a, out_valid_a); end
    endtask

    task automatic test_saturation;
        out_ready_b = 1'b1;
        for (int i = 0; i < 8; i++) send_b(9'd200);
        n_checks++; if (out_valid_b !== 1'b1) begin n_fail++; $display("FAIL sat_out_valid got %b want 1", out_valid_b); end
        n_checks++; if (sum_b !== 10'd1023) begin n_fail++; $display("FAIL sat_sum got %0d want 1023", sum_b); end
        n_checks++; if (sat_b !== 1'b1) begin n_fail++; $display("FAIL sat_flag got %b want 1", sat_b); end
        n_checks++; if (max_b !== 9'd200) begin n_fail++; $display("FAIL sat_max got %0d want 200", max_b); end
        idle(1);
        for (int i = 0; i < 8; i++) send_b(9'd1);
        n_checks++; if (out_valid_b !== 1'b1) begin n_fail++; $display("FAIL sat2_out_valid got %b want 1", out_valid_b); end
        n_checks++; if (sum_b !== 10'd8) begin n_fail++; $display("FAIL sat2_sum got %0d want 8", sum_b); end
        n_checks++; if (sat_b !== 1'b0) begin n_fail++; $display("FAIL sat2_flag got %b want 0", sat_b); end
        n_checks++; if (max_b !== 9'd1) begin n_fail++; $display("FAIL sat2_max got %0d want 1", max_b); end
        idle(1);
    endtask

    task automatic test_backpressure;
        out_ready_a = 1'b0;
        send_a(9'd1); send_a(9'd2); send_a(9'd3); send_a(9'd4);
        in_valid_a = 1'b1;
        diff_a     = 9'd7;
        for (int i = 0; i < 5; i++) begin
            n_checks++; if (in_ready_a !== 1'b0 || out_valid_a !== 1'b1) begin n_fail++; $display("FAIL bp_hold_%0d got rdy=%b ov=%b want 0/1", i, in_ready_a, out_valid_a); end
            n_checks++; if (sum_a !== 16'd10 || max_a !== 9'd4 || sat_a !== 1'b0) begin n_fail++; $display("FAIL bp_data_%0d got sum=%0d max=%0d sat=%b want 10/4/0", i, sum_a, max_a, sat_a); end
            @(posedge clk); #1;
        end
        in_valid_a  = 1'b0;
        out_ready_a = 1'b1;
        @(posedge clk); #1;
        n_checks++; if (in_ready_a !== 1'b1 || out_valid_a !== 1'b0) begin n_fail++; $display("FAIL bp_release got rdy=%b ov=%b want 1/0", in_ready_a, out_valid_a); end
        for (int i = 0; i < 4; i++) send_a(9'd1);
        n_checks++; if (out_valid_a !== 1'b1 || sum_a !== 16'd4 || max_a !== 9'd1) begin n_fail++; $display("FAIL bp_next_block got ov=%b sum=%0d max=%0d want 1/4/1", out_valid_a, sum_a, max_a); end
        idle(1);
    endtask

    task automatic test_flush;
        out_ready_a = 1'b1;
        send_a(9'd50); send_a(9'd60);
        flush_a = 1'b1;
        send_a(9'd70);
        flush_a = 1'b0;
        send_a(9'd1); send_a(9'd1); send_a(9'd1);
        n_checks++; if (out_valid_a !== 1'b0) begin n_fail++; $display("FAIL flush_early_valid got %b want 0", out_valid_a); end
        send_a(9'd1);
        n_checks++; if (out_valid_a !== 1'b1) begin n_fail++; $display("FAIL flush_out_valid got %b want 1", out_valid_a); end
        n_checks++; if (sum_a !== 16'd4) begin n_fail++; $display("FAIL flush_sum got %0d want 4", sum_a); end
        n_checks++; if (max_a !== 9'd1) begin n_fail++; $display("FAIL flush_max got %0d want 1", max_a); end
        idle(1);
    endtask

    task automatic test_bubbles;
        int results;
        results = 0;
        out_ready_a = 1'b1;
        send_a(9'd9); idle(1);
        send_a(9'd9); idle(2);
        send_a(9'd2);
        n_checks++; if (out_valid_a !== 1'b0) begin n_fail++; $display("FAIL bub_early_valid got %b want 0", out_valid_a); end
        send_a(9'd9);
        n_checks++; if (sum_a !== 16'd29 || max_a !== 9'd9 || sat_a !== 1'b0) begin n_fail++; $display("FAIL bub_result got sum=%0d max=%0d sat=%b want 29/9/0", sum_a, max_a, sat_a); end
        for (int i = 0; i < 6; i++) begin
            if (out_valid_a === 1'b1) results++;
            @(posedge clk); #1;
        end
        n_checks++; if (results !== 1) begin n_fail++; $display("FAIL bub_result_count got %0d want 1", results); end
    endtask

    task automatic test_async_reset;
        out_ready_a = 1'b1;
        send_a(9'd100); send_a(9'd100);
        #2 rst = 1'b1;
        #1;
        n_checks++; if (out_valid_a !== 1'b0 || in_ready_a !== 1'b1) begin n_fail++; $display("FAIL rst_mid_ctrl got ov=%b rdy=%b want 0/1", out_valid_a, in_ready_a); end
        @(negedge clk) rst = 1'b0;
        @(posedge clk); #1;
        for (int i = 0; i < 4; i++) send_a(9'd5);
        n_checks++; if (out_valid_a !== 1'b1 || sum_a !== 16'd20 || max_a !== 9'd5) begin n_fail++; $display("FAIL rst_mid_block got ov=%b sum=%0d max=%0d want 1/20/5", out_valid_a, sum_a, max_a); end
        idle(1);

        out_ready_a = 1'b0;
        send_a(9'd300); send_a(9'd1); send_a(9'd1); send_a(9'd1);
        n_checks++; if (out_valid_a !== 1'b1 || sum_a !== 16'd303) begin n_fail++; $display("FAIL rst_hold_setup got ov=%b sum=%0d want 1/303", out_valid_a, sum_a); end
        #2 rst = 1'b1;
        #1;
        n_checks++; if (out_valid_a !== 1'b0 || in_ready_a !== 1'b1) begin n_fail++; $display("FAIL rst_hold_ctrl got ov=%b rdy=%b want 0/1", out_valid_a, in_ready_a); end
        n_checks++; if (sum_a !== 16'd0 || max_a !== 9'd0 || sat_a !== 1'b0) begin n_fail++; $display("FAIL rst_hold_data got sum=%0d max=%0d sat=%b want 0", sum_a, max_a, sat_a); end
        @(negedge clk) rst = 1'b0;
        out_ready_a = 1'b1;
        @(posedge clk); #1;
        for (int i = 0; i < 4; i++) send_a(9'd5);
        n_checks++; if (out_valid_a !== 1'b1 || sum_a !== 16'd20 || max_a !== 9'd5) begin n_fail++; $display("FAIL rst_hold_next got ov=%b sum=%0d max=%0d want 1/20/5", out_valid_a, sum_a, max_a); end
        idle(1);
    endtask

    initial begin
        test_reset();
        test_back_to_back();
        test_saturation();
        test_backpressure();
        test_flush();
        test_bubbles();
        test_async_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/abs_diff_accum.md
# abs_diff_accum

Downstream consumer of the registered absolute-difference stage. Takes a stream of 9-bit |a−b| values through a valid/ready handshake and accumulates blocks of N samples into a saturating sum, the sum of absolute differences (SAD). It also tracks the block's maximum difference. Each completed block result is held on a valid/ready output until it is taken.

## Interface
- N, 8: samples per block; legal range 2..256.
- SUM_W, 16: width of the sum output; minimum 9.

- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous, active-high reset.
- in_valid  input  1  a difference sample is present on `diff`.
- in_ready  output  1  block can accept a sample this cycle.
- diff  input  9  unsigned absolute difference; the full 9-bit range is legal.
- flush  input  1  synchronous discard of the partial block.
- out_valid  output  1  block result is present on the outputs.
- out_ready  input  1  downstream takes the result.
- sum  output  SUM_W  saturated block sum.
- max_diff  output  9  largest `diff` in the block.
- sat  output  1  the block sum hit 2^SUM_W−1 and clamped.

## Operation
- Accept: a sample is taken when in_valid && in_ready on a rising clk edge.
- States:
  - ACC: accumulating; in_ready=1.
  - HOLD: result presented; in_ready=0.
- Internal registers:
  - acc: SUM_W bits.
  - mx: 9 bits.
  - cnt: 0..N−1.
  - ovf: 1 bit.
- Arithmetic: diff is zero-extended to SUM_W+1 bits and added to acc.
  - If the (SUM_W+1)-bit result exceeds 2^SUM_W−1, acc clamps to all ones and ovf is set.
  - Once ovf is set, acc stays clamped for the rest of the block.
- mx is updated to diff when diff > mx; ties keep the current value.
- Accept with cnt < N−1: acc, mx and ovf update; cnt increments; state stays ACC.
- Accept with cnt = N−1 (the Nth sample):
  - sum, max_diff and sat load the values that include this sample.
  - out_valid is set; state goes to HOLD.
  - acc, mx, ovf and cnt clear to 0.
- HOLD:
  - sum, max_diff and sat are stable.
  - When out_valid && out_ready, out_valid clears and state returns to ACC on the next edge.
- flush in ACC:
  - acc, mx, ovf and cnt clear.
  - Any sample accepted in the same cycle is discarded; flush wins.
- flush in HOLD: has no effect on the held result; the internal registers are already 0.
- in_valid while in_ready=0 is ignored. The upstream stage holds its data; no sample is lost or counted.

## Timing
- Reset (asserted asynchronously, released synchronously to clk):
  - out_valid=0, sum=0, max_diff=0, sat=0.
  - State ACC, so in_ready=1 from the first cycle after reset.
  - acc, mx, ovf and cnt are 0.
- Reset mid-block or in HOLD: all partial data and any held result are lost; the block restarts at cnt=0.
- in_ready is a registered state decode: in_ready = !out_valid. There is no combinational path from out_ready to in_ready.
- Latency: out_valid rises on the same edge that accepts the Nth sample, so it is visible the cycle after the Nth handshake.
- Throughput: one sample per clock while in ACC.
  - Each block costs N accept cycles plus at least 1 HOLD cycle.
  - Minimum block period is N+1 clocks with out_ready tied high.
- Bubbles (in_valid=0 in ACC) leave all state unchanged; cnt does not advance.
- out_valid, once high, stays high with stable data until out_ready is sampled high.

## Test plan
- N=4, SUM_W=16. Feed diff 3, 10, 0, 255 back-to-back with out_ready=1.
  - Expect out_valid one cycle after the 4th accept, with sum=268, max_diff=255, sat=0.
  - Expect in_ready high again the following cycle.
- Saturation: N=8, SUM_W=10, eight samples of 200. Expect sum=1023 and sat=1.
  - A following block of eight samples of 1 gives sum=8 and sat=0.
- Backpressure: complete a block, then hold out_ready=0 for 5 cycles with in_valid=1 and diff=7.
  - Expect in_ready=0 and sum/max_diff/sat stable throughout, with no samples counted.
  - After out_ready=1 for one cycle, expect in_ready=1 on the next cycle.
- Flush: N=4. Accept 50, 60, then assert flush in the same cycle as an accept of 70. Then accept 1, 1, 1, 1.
  - Expect sum=4, max_diff=1.
- Bubbles and ties: N=4. Feed 9, gap, 9, gap, gap, 2, 9.
  - Expect exactly one result, with sum=29 and max_diff=9.
- Reset: assert rst asynchronously after 2 of 4 samples, and separately during HOLD.
  - Expect out_valid=0 and all outputs 0 immediately.
  - The next 4 samples of 5 give sum=20.
